// File: rtl/hazard_ctrl_if.sv
// Decode/EX/MEM hazard inputs and pipeline-register control outputs of hazard_ctrl.
// Pure wiring, no latency; the pipeline drives the master side, hazard_ctrl the slave side.
interface hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       rs1_l1;
    logic [4:0]       rs2_l1;
    logic             use_rs1_l1;
    logic             use_rs2_l1;
    logic [4:0]       rd_l2;
    logic             ins_load_l2;
    logic             jump_l2;
    logic             dmem_req_l3;
    logic             dmem_ready;
    logic             err_clr;

    logic             block_pc;
    logic             block_l1;
    logic             block_l2;
    logic             block_l3;
    logic             clear_l1;
    logic             clear_l2;
    logic             clear_l3;
    logic             clear_l4;
    logic             halted;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output rs1_l1, rs2_l1, use_rs1_l1, use_rs2_l1, rd_l2, ins_load_l2,
               jump_l2, dmem_req_l3, dmem_ready, err_clr,
        input  block_pc, block_l1, block_l2, block_l3,
               clear_l1, clear_l2, clear_l3, clear_l4,
               halted, stall_cnt, flush_cnt
    );

    modport slave (
        input  rs1_l1, rs2_l1, use_rs1_l1, use_rs2_l1, rd_l2, ins_load_l2,
               jump_l2, dmem_req_l3, dmem_ready, err_clr,
        output block_pc, block_l1, block_l2, block_l3,
               clear_l1, clear_l2, clear_l3, clear_l4,
               halted, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_ctrl.sv
// 5-stage pipeline hazard control: dmem-wait stall, jump flush, load-use bubble, timeout halt.
// Block/clear outputs are combinational (same cycle); FSM and saturating counters are registered.
module hazard_ctrl #(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 32
) (
    input  logic          clk,
    input  logic          rst,
    hazard_ctrl_if.slave  hif
);
    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_MEM_WAIT = 2'd1;
    localparam logic [1:0] ST_TIMEOUT  = 2'd2;

    localparam int              WAIT_W    = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    logic [1:0]        state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

    logic mem_stall;
    logic load_use;
    logic in_timeout;
    logic do_jump;
    logic blk_pc, blk_l1, blk_l2, blk_l3;
    logic clr_l1, clr_l2, clr_l4;

    assign in_timeout = (state_q == ST_TIMEOUT);
    assign mem_stall  = ~in_timeout & hif.dmem_req_l3 & ~hif.dmem_ready;
    assign load_use   = hif.ins_load_l2 & (hif.rd_l2 != 5'd0) &
                        ((hif.use_rs1_l1 & (hif.rs1_l1 == hif.rd_l2)) |
                         (hif.use_rs2_l1 & (hif.rs2_l1 == hif.rd_l2)));

    // One action per cycle; everything is suppressed while reset is held.
    always_comb begin
        blk_pc  = 1'b0;
        blk_l1  = 1'b0;
        blk_l2  = 1'b0;
        blk_l3  = 1'b0;
        clr_l1  = 1'b0;
        clr_l2  = 1'b0;
        clr_l4  = 1'b0;
        do_jump = 1'b0;
        if (rst) begin
            blk_pc = 1'b0;
        end else if (in_timeout || mem_stall) begin
            blk_pc = 1'b1;
            blk_l1 = 1'b1;
            blk_l2 = 1'b1;
            blk_l3 = 1'b1;
            clr_l4 = 1'b1;
        end else if (hif.jump_l2) begin
            clr_l1  = 1'b1;
            clr_l2  = 1'b1;
            do_jump = 1'b1;
        end else if (load_use) begin
            blk_pc = 1'b1;
            blk_l1 = 1'b1;
            clr_l2 = 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            ST_RUN: begin
                if (mem_stall) begin
                    state_d    = ST_MEM_WAIT;
                    wait_cnt_d = WAIT_W'(1);
                end
            end
            ST_MEM_WAIT: begin
                if (hif.dmem_ready) begin
                    state_d    = ST_RUN;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d = ST_TIMEOUT;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end
            ST_TIMEOUT: begin
                if (hif.err_clr) begin
                    state_d    = ST_RUN;
                    wait_cnt_d = '0;
                end
            end
            default: begin
                state_d    = ST_RUN;
                wait_cnt_d = '0;
            end
        endcase
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (blk_pc && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (do_jump && (flush_cnt_q != {CNT_W{1'b1}})) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RUN;
            wait_cnt_q  <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign hif.block_pc  = blk_pc;
    assign hif.block_l1  = blk_l1;
    assign hif.block_l2  = blk_l2;
    assign hif.block_l3  = blk_l3;
    assign hif.clear_l1  = clr_l1;
    assign hif.clear_l2  = clr_l2;
    assign hif.clear_l3  = 1'b0;
    assign hif.clear_l4  = clr_l4;
    assign hif.halted    = in_timeout & ~rst;
    assign hif.stall_cnt = stall_cnt_q;
    assign hif.flush_cnt = flush_cnt_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with MEM_TIMEOUT=4 and 4-bit counters (exposes saturation).
module tb_hazard_ctrl;
    localparam int CNT_W = 4;

    // {block_pc, block_l1, block_l2, block_l3, clear_l1, clear_l2, clear_l3, clear_l4}
    localparam logic [7:0] CT_NONE = 8'b0000_0000;
    localparam logic [7:0] CT_MEM  = 8'b1111_0001;
    localparam logic [7:0] CT_JMP  = 8'b0000_1100;
    localparam logic [7:0] CT_LU   = 8'b1100_0100;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    hazard_ctrl_if #(.CNT_W(CNT_W)) hif ();

    hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(CNT_W)) u_dut (
        .clk (clk),
        .rst (rst),
        .hif (hif)
    );

    always #5 clk = ~clk;

    logic [7:0] ctrl;
    assign ctrl = {hif.block_pc, hif.block_l1, hif.block_l2, hif.block_l3,
                   hif.clear_l1, hif.clear_l2, hif.clear_l3, hif.clear_l4};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one clock and land 1 ns after the edge, where inputs are changed.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        hif.rs1_l1      = 5'd0;
        hif.rs2_l1      = 5'd0;
        hif.use_rs1_l1  = 1'b0;
        hif.use_rs2_l1  = 1'b0;
        hif.rd_l2       = 5'd0;
        hif.ins_load_l2 = 1'b0;
        hif.jump_l2     = 1'b0;
        hif.dmem_req_l3 = 1'b0;
        hif.dmem_ready  = 1'b0;
        hif.err_clr     = 1'b0;
    endtask

    initial begin
        idle();
        rst = 1'b1;

        // T1: reset held, outputs forced idle even with a pending stall on the inputs
        hif.dmem_req_l3 = 1'b1;
        #1;
        chk("rst_ctrl", 32'(ctrl), 32'(CT_NONE));
        chk("rst_halted", 32'(hif.halted), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        idle();
        #1;
        chk("t1_ctrl", 32'(ctrl), 32'(CT_NONE));
        chk("t1_halted", 32'(hif.halted), 32'd0);
        chk("t1_stall", 32'(hif.stall_cnt), 32'd0);
        chk("t1_flush", 32'(hif.flush_cnt), 32'd0);
        tick();

        // T2: lw x5 in EX, decode reads x5 via rs2
        hif.ins_load_l2 = 1'b1;
        hif.rd_l2       = 5'd5;
        hif.rs2_l1      = 5'd5;
        hif.use_rs2_l1  = 1'b1;
        #1;
        chk("t2_lu", 32'(ctrl), 32'(CT_LU));
        tick();
        hif.ins_load_l2 = 1'b0;
        hif.rd_l2       = 5'd9;
        #1;
        chk("t2_after", 32'(ctrl), 32'(CT_NONE));
        chk("t2_stall", 32'(hif.stall_cnt), 32'd1);
        hif.ins_load_l2 = 1'b1;
        hif.rd_l2       = 5'd0;
        hif.rs2_l1      = 5'd0;
        #1;
        chk("t2_rd0", 32'(ctrl), 32'(CT_NONE));
        tick();
        // rs1 path, and the same match without use_rs1 must not stall
        idle();
        hif.ins_load_l2 = 1'b1;
        hif.rd_l2       = 5'd7;
        hif.rs1_l1      = 5'd7;
        #1;
        chk("t2_nouse", 32'(ctrl), 32'(CT_NONE));
        hif.use_rs1_l1 = 1'b1;
        #1;
        chk("t2_rs1_lu", 32'(ctrl), 32'(CT_LU));
        tick();
        idle();
        #1;
        chk("t2_stall2", 32'(hif.stall_cnt), 32'd2);

        // T3: jump beats load-use
        hif.ins_load_l2 = 1'b1;
        hif.rd_l2       = 5'd5;
        hif.rs2_l1      = 5'd5;
        hif.use_rs2_l1  = 1'b1;
        hif.jump_l2     = 1'b1;
        #1;
        chk("t3_jmp", 32'(ctrl), 32'(CT_JMP));
        tick();
        idle();
        #1;
        chk("t3_flush", 32'(hif.flush_cnt), 32'd1);
        chk("t3_stall", 32'(hif.stall_cnt), 32'd2);

        // T4: three dmem wait cycles, then ready
        hif.dmem_req_l3 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t4_wait", 32'(ctrl), 32'(CT_MEM));
            tick();
        end
        hif.dmem_ready = 1'b1;
        #1;
        chk("t4_release", 32'(ctrl), 32'(CT_NONE));
        tick();
        #1;
        chk("t4_stall", 32'(hif.stall_cnt), 32'd5);
        chk("t4_halted", 32'(hif.halted), 32'd0);
        chk("t4_zero_wait", 32'(ctrl), 32'(CT_NONE));
        tick();

        // T6: jump deferred behind a memory stall
        hif.dmem_ready = 1'b0;
        hif.jump_l2    = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("t6_stalled", 32'(ctrl), 32'(CT_MEM));
            tick();
        end
        chk("t6_flush_held", 32'(hif.flush_cnt), 32'd1);
        hif.dmem_ready = 1'b1;
        #1;
        chk("t6_jmp", 32'(ctrl), 32'(CT_JMP));
        tick();
        idle();
        #1;
        chk("t6_flush", 32'(hif.flush_cnt), 32'd2);
        chk("t6_stall", 32'(hif.stall_cnt), 32'd7);

        // T5: dmem never ready, TIMEOUT on the fifth stalled cycle
        hif.dmem_req_l3 = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            #1;
            chk("t5_wait", 32'(ctrl), 32'(CT_MEM));
            chk("t5_not_halt", 32'(hif.halted), 32'd0);
            tick();
        end
        #1;
        chk("t5_halted", 32'(hif.halted), 32'd1);
        chk("t5_to_ctrl", 32'(ctrl), 32'(CT_MEM));
        tick();
        hif.dmem_ready = 1'b1;
        #1;
        chk("t5_sticky", 32'(hif.halted), 32'd1);
        chk("t5_sticky_ctrl", 32'(ctrl), 32'(CT_MEM));
        tick();
        hif.err_clr = 1'b1;
        #1;
        chk("t5_clr_cycle", 32'(hif.halted), 32'd1);
        tick();
        idle();
        #1;
        chk("t5_released", 32'(hif.halted), 32'd0);
        chk("t5_rel_ctrl", 32'(ctrl), 32'(CT_NONE));
        chk("t5_stall", 32'(hif.stall_cnt), 32'd14);

        // Reset in the middle of MEM_WAIT
        hif.dmem_req_l3 = 1'b1;
        tick();
        rst = 1'b1;
        #1;
        chk("rst_mw_ctrl", 32'(ctrl), 32'(CT_NONE));
        tick();
        rst = 1'b0;
        idle();
        #1;
        chk("rst_mw_stall", 32'(hif.stall_cnt), 32'd0);
        chk("rst_mw_flush", 32'(hif.flush_cnt), 32'd0);
        chk("rst_mw_state", 32'(ctrl), 32'(CT_NONE));

        // Stall counter saturation: 20 blocked cycles into a 4-bit counter
        hif.dmem_req_l3 = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        chk("sat_stall", 32'(hif.stall_cnt), 32'hF);
        chk("sat_halted", 32'(hif.halted), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
